// File: rtl/pll_lock_seq_pkg.sv
// Shared types for the PLL lock sequencer: state encoding and a sizing helper.
package pll_lock_seq_pkg;

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      STABILIZE = 2'd2,
      RUN       = 2'd3
   } state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL lock flag into the refclk domain.
module pll_lock_sync #(
   parameter int STAGES = 2
) (
   input  logic gclk,
   input  logic grst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_pipe;

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) sync_pipe <= '0;
      else         sync_pipe <= {sync_pipe[STAGES-2:0], d};
   end

   assign q = sync_pipe[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset pulses, waits for a stable lock, and releases the system reset.
module pll_lock_sequencer
   import pll_lock_seq_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int CNT_W               = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pll_locked,
   input  logic             force_reset,
   input  logic             clear_counts,
   output logic             pll_rst,
   output logic             sys_reset_n,
   output logic             ready,
   output logic [CNT_W-1:0] loss_count,
   output logic [CNT_W-1:0] timeout_count,
   output logic [1:0]       state_o
);

   localparam int CYC_W = $clog2(max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)) + 1;
   localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(PLL_RST_CYCLES - 1);
   localparam logic [CYC_W-1:0] STB_LAST = CYC_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CYC_W-1:0] TMO_LAST = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);

   state_e           state, state_nx;
   logic [CYC_W-1:0] cyc, cyc_nx;
   logic             locked_s;
   logic             loss_inc, tmo_inc;

   pll_lock_sync #(.STAGES(2)) u_sync (
      .gclk   (clk),
      .grst_n (reset_n),
      .d      (pll_locked),
      .q      (locked_s)
   );

   // Every state change clears the cycle counter; force_reset overrides all arcs.
   always_comb begin
      state_nx = state;
      cyc_nx   = cyc + 1'b1;
      loss_inc = 1'b0;
      tmo_inc  = 1'b0;
      if (force_reset) begin
         state_nx = PLL_RESET;
         cyc_nx   = '0;
      end else begin
         case (state)
            PLL_RESET: begin
               if (cyc == RST_LAST) begin
                  state_nx = WAIT_LOCK;
                  cyc_nx   = '0;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state_nx = STABILIZE;
                  cyc_nx   = '0;
               end else if (cyc == TMO_LAST) begin
                  state_nx = PLL_RESET;
                  cyc_nx   = '0;
                  tmo_inc  = 1'b1;
               end
            end
            STABILIZE: begin
               if (!locked_s) begin
                  state_nx = WAIT_LOCK;
                  cyc_nx   = '0;
               end else if (cyc == STB_LAST) begin
                  state_nx = RUN;
                  cyc_nx   = '0;
               end
            end
            RUN: begin
               cyc_nx = '0;
               if (!locked_s) begin
                  state_nx = PLL_RESET;
                  loss_inc = 1'b1;
               end
            end
            default: begin
               state_nx = PLL_RESET;
               cyc_nx   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= PLL_RESET;
         cyc         <= '0;
         pll_rst     <= 1'b1;
         sys_reset_n <= 1'b0;
         ready       <= 1'b0;
      end else begin
         state       <= state_nx;
         cyc         <= cyc_nx;
         pll_rst     <= (state_nx == PLL_RESET);
         sys_reset_n <= (state_nx == RUN);
         ready       <= (state_nx == RUN);
      end
   end

   // Saturating event counters; a clear beats a same-cycle increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         loss_count    <= '0;
         timeout_count <= '0;
      end else if (clear_counts) begin
         loss_count    <= '0;
         timeout_count <= '0;
      end else begin
         if (loss_inc && loss_count != '1)   loss_count    <= loss_count + 1'b1;
         if (tmo_inc && timeout_count != '1) timeout_count <= timeout_count + 1'b1;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for the PLL lock sequencer with small parameters.
module tb_pll_lock_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       pll_locked;
   logic       force_reset;
   logic       clear_counts;
   logic       pll_rst;
   logic       sys_reset_n;
   logic       ready;
   logic [3:0] loss_count;
   logic [3:0] timeout_count;
   logic [1:0] state_o;

   int checks   = 0;
   int failures = 0;

   pll_lock_sequencer #(
      .PLL_RST_CYCLES      (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (32),
      .CNT_W               (4)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pll_locked    (pll_locked),
      .force_reset   (force_reset),
      .clear_counts  (clear_counts),
      .pll_rst       (pll_rst),
      .sys_reset_n   (sys_reset_n),
      .ready         (ready),
      .loss_count    (loss_count),
      .timeout_count (timeout_count),
      .state_o       (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves reset released just after an edge, so the next edge is edge 1.
   task automatic do_reset(input logic lock_val);
      reset_n    = 1'b0;
      pll_locked = lock_val;
      tick(2);
      reset_n = 1'b1;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!ready && n < 40) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(ready), 32'd1);
   endtask

   // One-cycle lock drop while in RUN, then wait for the sequencer to return to RUN.
   task automatic lose_lock(input string tag);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(3);
      wait_ready(tag);
   endtask

   initial begin
      bit ok_hi;
      bit rdy_seen;
      force_reset  = 1'b0;
      clear_counts = 1'b0;

      // Reset state and clean lock-up
      do_reset(1'b1);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_pll_rst", 32'(pll_rst), 32'd1);
      chk("rst_sysn", 32'(sys_reset_n), 32'd0);
      tick(1);  chk("a_e1_pll_rst", 32'(pll_rst), 32'd1);
      tick(2);  chk("a_e3_pll_rst", 32'(pll_rst), 32'd1);
      tick(1);  chk("a_e4_pll_rst", 32'(pll_rst), 32'd0);
      chk("a_e4_state", 32'(state_o), 32'd1);
      tick(1);  chk("a_e5_state", 32'(state_o), 32'd2);
      tick(7);  chk("a_e12_ready", 32'(ready), 32'd0);
      tick(1);  chk("a_e13_ready", 32'(ready), 32'd1);
      chk("a_e13_sysn", 32'(sys_reset_n), 32'd1);
      ok_hi = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         ok_hi &= ready & sys_reset_n;
      end
      chk("a_stay_high", 32'(ok_hi), 32'd1);
      chk("a_loss", 32'(loss_count), 32'd0);
      chk("a_tmo", 32'(timeout_count), 32'd0);

      // Single-cycle lock loss in RUN (E0 = current point)
      pll_locked = 1'b0;
      tick(1);  pll_locked = 1'b1;
      tick(1);  chk("c_e2_ready", 32'(ready), 32'd1);
      tick(1);  chk("c_e3_ready", 32'(ready), 32'd0);
      chk("c_e3_sysn", 32'(sys_reset_n), 32'd0);
      chk("c_e3_pll_rst", 32'(pll_rst), 32'd1);
      chk("c_e3_loss", 32'(loss_count), 32'd1);
      tick(3);  chk("c_e6_pll_rst", 32'(pll_rst), 32'd1);
      tick(1);  chk("c_e7_pll_rst", 32'(pll_rst), 32'd0);
      tick(1);  chk("c_e8_state", 32'(state_o), 32'd2);
      tick(7);  chk("c_e15_ready", 32'(ready), 32'd0);
      tick(1);  chk("c_e16_ready", 32'(ready), 32'd1);

      // No lock at all: timeouts every 36 cycles
      do_reset(1'b0);
      rdy_seen = 1'b0;
      for (int e = 1; e <= 100; e++) begin
         tick(1);
         rdy_seen |= ready;
         if (e == 35) chk("b_e35_pll_rst", 32'(pll_rst), 32'd0);
         if (e == 36) chk("b_e36_pll_rst", 32'(pll_rst), 32'd1);
         if (e == 36) chk("b_e36_tmo", 32'(timeout_count), 32'd1);
         if (e == 39) chk("b_e39_pll_rst", 32'(pll_rst), 32'd1);
         if (e == 40) chk("b_e40_pll_rst", 32'(pll_rst), 32'd0);
         if (e == 71) chk("b_e71_pll_rst", 32'(pll_rst), 32'd0);
         if (e == 72) chk("b_e72_pll_rst", 32'(pll_rst), 32'd1);
      end
      chk("b_tmo_100", 32'(timeout_count), 32'd2);
      chk("b_never_ready", 32'(rdy_seen), 32'd0);

      // Glitch during STABILIZE at stable count 6
      do_reset(1'b1);
      tick(9);  pll_locked = 1'b0;
      tick(1);  pll_locked = 1'b1;
      tick(1);  chk("d_e11_state", 32'(state_o), 32'd2);
      tick(1);  chk("d_e12_state", 32'(state_o), 32'd1);
      tick(1);  chk("d_e13_state", 32'(state_o), 32'd2);
      tick(7);  chk("d_e20_state", 32'(state_o), 32'd2);
      tick(1);  chk("d_e21_state", 32'(state_o), 32'd3);

      // Loss counter saturation and clear priority
      for (int k = 0; k < 15; k++) lose_lock("e_relock");
      chk("e_loss_15", 32'(loss_count), 32'd15);
      lose_lock("e_relock_sat");
      chk("e_loss_sat", 32'(loss_count), 32'd15);
      pll_locked = 1'b0;
      tick(1);  pll_locked = 1'b1;
      tick(1);  clear_counts = 1'b1;
      tick(1);  clear_counts = 1'b0;
      chk("e_clr_state", 32'(state_o), 32'd0);
      chk("e_clr_loss", 32'(loss_count), 32'd0);
      tick(3);
      wait_ready("e_relock_clr");
      lose_lock("e_relock_one");
      chk("e_loss_1", 32'(loss_count), 32'd1);

      // force_reset in RUN, re-force during PLL_RESET, then async reset mid-STABILIZE
      force_reset = 1'b1;
      tick(1);  force_reset = 1'b0;
      chk("f_f0_state", 32'(state_o), 32'd0);
      chk("f_f0_ready", 32'(ready), 32'd0);
      chk("f_f0_loss", 32'(loss_count), 32'd1);
      tick(1);  force_reset = 1'b1;
      tick(1);  force_reset = 1'b0;
      tick(3);  chk("f_f5_state", 32'(state_o), 32'd0);
      tick(1);  chk("f_f6_state", 32'(state_o), 32'd1);
      tick(1);  chk("f_f7_state", 32'(state_o), 32'd2);
      tick(1);
      chk("f_f8_loss", 32'(loss_count), 32'd1);
      chk("f_f8_tmo", 32'(timeout_count), 32'd0);
      reset_n = 1'b0;
      #1;
      chk("g_state", 32'(state_o), 32'd0);
      chk("g_pll_rst", 32'(pll_rst), 32'd1);
      chk("g_sysn", 32'(sys_reset_n), 32'd0);
      chk("g_ready", 32'(ready), 32'd0);
      chk("g_loss", 32'(loss_count), 32'd0);
      chk("g_tmo", 32'(timeout_count), 32'd0);
      tick(1);
      reset_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, the number of cycles pll_rst is held high per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, the number of consecutive cycles synchronized lock must stay high before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, the number of cycles to wait for lock before re-pulsing the PLL.
REQ-004 SHALL have parameter CNT_W, default 8, the width of the event counters.
REQ-005 SHALL have port clk, input, 1 bit: free-running reference clock (the PLL refclk domain, never the PLL output).
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL locked flag, asynchronous to clk.
REQ-008 SHALL have port force_reset, input, 1 bit: single-cycle request to re-pulse the PLL.
REQ-009 SHALL have port clear_counts, input, 1 bit: single-cycle clear of both event counters.
REQ-010 SHALL have port pll_rst, output, 1 bit: active-high reset driven to the PLL rst input.
REQ-011 SHALL have port sys_reset_n, output, 1 bit: active-low reset for logic clocked by the PLL output; the consumer synchronizes it.
REQ-012 SHALL have port ready, output, 1 bit: high only while the PLL is stably locked.
REQ-013 SHALL have port loss_count, output, CNT_W bits: saturating count of lock losses seen in RUN.
REQ-014 SHALL have port timeout_count, output, CNT_W bits: saturating count of lock-wait timeouts.
REQ-015 SHALL have port state_o, output, 2 bits: current state encoding.

Function
REQ-016 SHALL pass pll_locked through a 2-flop synchronizer (reset value 0); locked_s is the synchronizer output, and all decisions SHALL use locked_s only.
REQ-017 SHALL implement four states: PLL_RESET=0, WAIT_LOCK=1, STABILIZE=2, RUN=3.
REQ-018 In PLL_RESET, pll_rst SHALL be 1 for exactly PLL_RST_CYCLES cycles, then the block SHALL enter WAIT_LOCK with the cycle counter cleared.
REQ-019 In WAIT_LOCK, locked_s=1 SHALL cause a transition to STABILIZE with the counter cleared.
REQ-020 In WAIT_LOCK, if the counter reaches LOCK_TIMEOUT_CYCLES-1 without lock, the block SHALL enter PLL_RESET and increment timeout_count.
REQ-021 In STABILIZE, locked_s=0 SHALL return the block to WAIT_LOCK with the counter cleared.
REQ-022 In STABILIZE, LOCK_STABLE_CYCLES consecutive cycles with locked_s=1 SHALL cause a transition to RUN.
REQ-023 In RUN, locked_s=0 SHALL cause a transition to PLL_RESET and increment loss_count.
REQ-024 force_reset=1 in any state SHALL cause a transition to PLL_RESET next cycle, with priority over all other transitions; it SHALL NOT increment either counter.
REQ-025 A force_reset during PLL_RESET SHALL restart the PLL_RST_CYCLES count.
REQ-026 All outputs SHALL be registered and decoded from next state, so they change on the same edge as the state: pll_rst=1 only in PLL_RESET; ready=1 and sys_reset_n=1 only in RUN.
REQ-027 Counters SHALL saturate at 2^CNT_W-1.
REQ-028 clear_counts SHALL zero both counters next cycle and SHALL win over a simultaneous increment.
REQ-029 The cycle counter SHALL be sized $clog2 of the largest of the three cycle parameters, plus 1 bit.

Reset
REQ-030 Assertion of reset_n low SHALL immediately force state=PLL_RESET, pll_rst=1, sys_reset_n=0, ready=0, both counters 0, the cycle counter 0, and the synchronizer flops 0.
REQ-031 Reset asserted mid-operation, in any state, SHALL produce identical results.
REQ-032 After reset_n deasserts, the block SHALL begin a full PLL_RST_CYCLES pulse.

Structure
REQ-033 The state enum and its encoding SHALL reside in package pll_lock_seq_pkg.
REQ-034 The synchronizer SHALL be a sub-module named pll_lock_sync, instantiated once.

Verification (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, CNT_W=4)
REQ-035 Bench SHALL hold pll_locked=1 from reset release -> pll_rst high for edges 1-4, ready and sys_reset_n rise at edge 13 and stay high, counters 0.
REQ-036 Bench SHALL hold pll_locked=0 for 100 cycles -> pll_rst re-pulses every 36 cycles, timeout_count=2 at cycle 100, ready=0 throughout.
REQ-037 Bench SHALL, in RUN, drop pll_locked for 1 cycle -> ready and sys_reset_n fall 3 edges later, pll_rst pulses 4 cycles, loss_count=1, ready returns after relock plus 9 cycles.
REQ-038 Bench SHALL, in STABILIZE, glitch pll_locked low at stable count 6 -> return to WAIT_LOCK, and the full 8-cycle stabilize SHALL restart.
REQ-039 Bench SHALL drive loss_count to 15, then cause one more loss -> loss_count stays 15; clear_counts coincident with a loss -> loss_count=0.
REQ-040 Bench SHALL assert force_reset in RUN, then reset_n low mid-STABILIZE -> PLL_RESET next edge with counters unchanged; reset gives all outputs at their reset values asynchronously.
